// File: rtl/cond_pkg.sv
// Shared definitions for condition evaluation: condition codes, flag layout and flag vector type.
package cond_pkg;

    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition-code evaluation against an {N,Z,C,V} flag vector.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV register plus condition gating of the decoder's commit enables.
module cond_unit
    import cond_pkg::*;
#(
    parameter logic [FLAG_W-1:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       pc_src_in,
    input  logic       reg_write_in,
    input  logic       mem_write_in,
    input  logic       no_write_in,
    input  logic [1:0] flag_write_in,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic       undef
);

    flags_t flags_q, flags_d;
    logic   undef_q, undef_d;
    logic   cond_pass;

    // Evaluated on committed flags only, so an instruction never sees its own ALU result.
    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_comb begin
        cond_ex   = en & cond_pass;
        pc_src    = pc_src_in & cond_ex;
        reg_write = reg_write_in & ~no_write_in & cond_ex;
        mem_write = mem_write_in & cond_ex;

        flags_d = flags_q;
        if (cond_ex) begin
            if (flag_write_in[1]) begin
                flags_d[FLAG_N] = alu_flags[FLAG_N];
                flags_d[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (flag_write_in[0]) begin
                flags_d[FLAG_C] = alu_flags[FLAG_C];
                flags_d[FLAG_V] = alu_flags[FLAG_V];
            end
        end

        undef_d = undef_q | (en & (cond == 4'(NV)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= RESET_FLAGS;
            undef_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            undef_q <= undef_d;
        end
    end

    assign flags = flags_q;
    assign undef = undef_q;

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the control-unit decoder outputs.
- Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against the registered flags.
- Gates the decoder's raw pc_src, reg_write, mem_write and flag_write so that only a passing instruction commits state.
- Sits between the decoder and the datapath write enables of the single-cycle processor.

Parameters:
- FLAG_W, 4, width of the flag vector {N,Z,C,V}; fixed at 4, exposed for the shared package.
- RESET_FLAGS, 4'b0000, flag register value after reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  instruction-valid/advance; when 0, no state update and all gated outputs are 0.
- cond  input  4  instruction condition field, Instr[31:28].
- alu_flags  input  4  ALU result flags {N,Z,C,V} of the current instruction.
- pc_src_in  input  1  raw pc_src from the decoder.
- reg_write_in  input  1  raw reg_write from the decoder.
- mem_write_in  input  1  raw mem_write from the decoder.
- no_write_in  input  1  decoder compare indication (CMP/CMN); suppresses the register write.
- flag_write_in  input  2  raw flag_write; [1] enables the N,Z update, [0] enables the C,V update.
- pc_src  output  1  gated PC select.
- reg_write  output  1  gated register-file write enable.
- mem_write  output  1  gated data-memory write enable.
- cond_ex  output  1  condition passed for the current instruction.
- flags  output  4  current registered {N,Z,C,V}.
- undef  output  1  sticky: an instruction with cond=4'b1111 was presented with en=1.

Behaviour:
- Condition evaluation is combinational on the registered flags, never on alu_flags. An instruction sees the flags committed by earlier instructions.
- cond decode:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved)
- cond_ex = en & decoded condition.
- Gated outputs, combinational, zero latency:
  - pc_src = pc_src_in & cond_ex
  - reg_write = reg_write_in & ~no_write_in & cond_ex
  - mem_write = mem_write_in & cond_ex
- Flag register update at the rising clk edge when cond_ex=1:
  - If flag_write_in[1]=1: N,Z <= alu_flags[3:2].
  - If flag_write_in[0]=1: C,V <= alu_flags[1:0].
  - Halves update independently. flag_write_in=2'b00 leaves the flags unchanged.
- A failed condition (cond_ex=0) leaves the flags unchanged, even if flag_write_in≠0.
- Flags written in cycle t are visible to cond evaluation in cycle t+1.
- undef is set at the edge following en=1 & cond=4'b1111. It stays set until rst.
- rst (synchronous) has priority over all updates:
  - flags <= RESET_FLAGS, undef <= 0.
  - Gated outputs follow the combinational rules using the reset flags from the next cycle onward.
- en=0: all gated outputs 0, flags and undef hold, regardless of the other inputs.
- Reset asserted during an en=1 cycle: no flag update occurs in that cycle.
- No X propagation: every output is driven by a defined function of registered state and inputs.

Decomposition:
- Shared package cond_pkg holds:
  - Enum cond_e (EQ..AL, NV=4'b1111).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Typedef flags_t (logic [3:0]).
- Natural sub-module: cond_check, the purely combinational cond × flags → pass function. It is reused by future branch-prediction/debug logic.
- Flag registers and output gating stay in cond_unit.

Test Plan:
- Reset with rst=1 for 2 cycles → flags=0000, undef=0. Then cond=0001 (NE), reg_write_in=1, en=1 → reg_write=1, cond_ex=1.
- SUBS producing zero: cond=1110, flag_write_in=11, alu_flags=0110 → next cycle flags=0110. Then BEQ (cond=0000, pc_src_in=1) → pc_src=1. BNE (cond=0001) instead → pc_src=0.
- Partial update from flags=0000: cond=1110, flag_write_in=10, alu_flags=1011 → flags=1000 (C,V untouched). Then flag_write_in=01, alu_flags=0111 → flags=1011.
- Failed condition from flags=0100: cond=0001, flag_write_in=11, alu_flags=1001, mem_write_in=1 → mem_write=0, flags remain 0100.
- CMP gating: cond=1110, reg_write_in=1, no_write_in=1, flag_write_in=11, alu_flags=1000 → reg_write=0, next flags=1000. Then cond=1011 (LT) → cond_ex=1.
- cond=1111 with en=1 → cond_ex=0, all gated outputs 0, undef=1 next cycle and held. en=0 with cond=1110, flag_write_in=11 → no change. rst → undef=0.
